aidan_mcnay_debounce: RTL and testbench
=======================================

Name: aidan_mcnay_debounce

Overview:
- Upstream conditioning stage for the change detector.
- Takes a raw, asynchronous, bouncy input (e.g. a pushbutton or external strobe), synchronizes it into the `clk` domain, and filters it with a consecutive-cycle stability counter.
- `out_signal` is a clean, glitch-free level that feeds the change detector's `in_signal` directly.
- Also reports whether a candidate transition is being qualified.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops. Legal range ≥ 2.
- DEBOUNCE_CYCLES, 1000: number of consecutive synchronized samples at the new value required before `out_signal` flips. Legal range 1 .. 65535.
- CNT_WIDTH (localparam), `$clog2(DEBOUNCE_CYCLES+1)`: counter width. Minimum 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_signal  input  1  raw input; asynchronous to `clk`, may bounce or glitch.
- out_signal  output  1  debounced level; registered.
- busy  output  1  high while a candidate transition is being counted; registered.

Behaviour:
- Reset: asynchronous assert, synchronous deassert by the system.
  - While `rst`=1: all synchronizer flops=0, `out_signal`=0, `busy`=0, counter=0, state=STABLE.
  - Reset asserted mid-count aborts the qualification immediately. No flip occurs.
- Synchronizer:
  - `in_signal` is shifted through SYNC_STAGES flops.
  - `s` denotes the last flop's output.
  - Only `s` feeds the filter logic. No other path from `in_signal`.
- FSM has 2 states, STABLE and COUNT. `busy` = (state==COUNT), registered.
- STABLE:
  - If `s`==`out_signal`: hold.
  - If `s`!=`out_signal` and DEBOUNCE_CYCLES==1: `out_signal`<=`s`, stay STABLE.
  - If `s`!=`out_signal` and DEBOUNCE_CYCLES>1: counter<=1, go to COUNT.
- COUNT:
  - If `s`==`out_signal`: counter<=0, go to STABLE. Bounce detected, no flip.
  - Else if counter==DEBOUNCE_CYCLES-1: `out_signal`<=~`out_signal`, counter<=0, go to STABLE.
  - Else: counter<=counter+1.
- Net effect: `out_signal` flips on the DEBOUNCE_CYCLES-th consecutive rising edge that samples `s` at the new value.
- Latency:
  - Edge e0 is the first rising edge at which `in_signal` is sampled at the new value, and `in_signal` is held thereafter.
  - `out_signal` changes immediately after edge e(SYNC_STAGES+DEBOUNCE_CYCLES-1).
  - That is SYNC_STAGES+DEBOUNCE_CYCLES edges inclusive of e0.
- Symmetry: rising and falling transitions are qualified identically.
- Counter never wraps: its maximum value is DEBOUNCE_CYCLES-1.
- Any single-cycle mismatch resets qualification fully. There is no partial credit across bounces.
- `out_signal` toggles at most once per DEBOUNCE_CYCLES cycles. A downstream change detector therefore never sees pulses closer than DEBOUNCE_CYCLES.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless noted.
1. Clean rise:
   - Stimulus: after reset, drive `in_signal` 0→1 before edge e0 and hold.
   - Required: `busy`=1 after e2 through e4; `out_signal`=1 after e5 (6 edges inclusive); `busy`=0 after e5.
2. Short glitch:
   - Stimulus: `in_signal` high for 3 cycles, then low.
   - Required: `busy` asserts for 3 cycles then drops; `out_signal` stays 0 throughout.
3. Bounce then settle:
   - Stimulus: `in_signal` pattern 1,0,1,1,0,1 at successive edges, then held at 1.
   - Required: no flip during the bounce; `out_signal` rises exactly 6 edges after the final 0→1 sample.
4. Clean fall:
   - Stimulus: with `out_signal`=1, drive `in_signal` 1→0 and hold.
   - Required: `out_signal`=0 after the 6th edge; `busy` behaves as in scenario 1.
5. Reset mid-count:
   - Stimulus: assert `rst` asynchronously while `busy`=1 with counter=2.
   - Required: `out_signal`, `busy` and counter go to 0 immediately, without waiting for `clk`; after release with `in_signal` still high, full 6-edge qualification restarts.
6. DEBOUNCE_CYCLES=1 corner:
   - Stimulus: toggle `in_signal` every 3 cycles.
   - Required: `out_signal` follows `in_signal` delayed by exactly 3 edges; `busy` is never asserted.

Source files
------------

// File: rtl/aidan_mcnay_debounce.sv
// Debouncer: synchronizes a raw asynchronous input and only lets out_signal
// flip after DEBOUNCE_CYCLES consecutive synchronized samples at the new level.
module aidan_mcnay_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic in_signal,
    output logic out_signal,
    output logic busy
);

    localparam int CNT_WIDTH = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   busy_q, busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= STABLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    // Only the last synchronizer stage is allowed to reach the filter.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_signal};
        s      = sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            STABLE: begin
                if (s != out_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        out_d = s;
                    end else begin
                        cnt_d   = CNT_WIDTH'(1);
                        state_d = COUNT;
                    end
                end
            end
            COUNT: begin
                // Any sample back at the old level discards all accumulated credit.
                if (s == out_q) begin
                    cnt_d   = '0;
                    state_d = STABLE;
                end else if (cnt_q == CNT_LAST) begin
                    out_d   = ~out_q;
                    cnt_d   = '0;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
        endcase
        busy_d = (state_d == COUNT);
    end

    assign out_signal = out_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_aidan_mcnay_debounce.sv
// Bench for aidan_mcnay_debounce: directed scenarios plus random stimulus,
// checked against a run-length reference model (DEBOUNCE_CYCLES=4 and =1).
module tb_aidan_mcnay_debounce;

    localparam int S = 2;

    logic clk;
    logic rst;
    logic in4, in1;
    logic out4, busy4, out1, busy1;

    int n_chk;
    int n_fail;

    aidan_mcnay_debounce #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_signal (in4),
        .out_signal(out4),
        .busy      (busy4)
    );

    aidan_mcnay_debounce #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_signal (in1),
        .out_signal(out1),
        .busy      (busy1)
    );

    always #5 clk = ~clk;

    // Reference model: each instance remembers raw samples for S edges, then
    // counts how many consecutive delayed samples differ from the output.
    int   md[2] = '{4, 1};
    logic mout[2];
    int   mrun[2];
    logic q0[$];
    logic q1[$];

    task automatic model_reset();
        q0 = {};
        q1 = {};
        for (int i = 0; i < S; i++) begin
            q0.push_back(1'b0);
            q1.push_back(1'b0);
        end
        for (int m = 0; m < 2; m++) begin
            mout[m] = 1'b0;
            mrun[m] = 0;
        end
    endtask

    task automatic model_edge(input int m, input logic din);
        logic seen;
        if (m == 0) begin
            seen = q0.pop_front();
            q0.push_back(din);
        end else begin
            seen = q1.pop_front();
            q1.push_back(din);
        end
        if (seen != mout[m]) begin
            mrun[m]++;
            if (mrun[m] == md[m]) begin
                mout[m] = ~mout[m];
                mrun[m] = 0;
            end
        end else begin
            mrun[m] = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: model steps on the rising edge, DUTs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else begin
            model_edge(0, in4);
            model_edge(1, in1);
        end
        @(negedge clk);
        chk("out4", out4, mout[0]);
        chk("busy4", busy4, (mrun[0] > 0));
        chk("out1", out1, mout[1]);
        chk("busy1", busy1, (mrun[1] > 0));
    endtask

    // DEBOUNCE_CYCLES=1 instance: toggle every 3 cycles throughout.
    initial begin
        in1 = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            in1 = ~in1;
        end
    end

    initial begin
        int n;
        int bcnt;
        logic pat[6];
        clk    = 1'b0;
        rst    = 1'b1;
        in4    = 1'b0;
        n_chk  = 0;
        n_fail = 0;
        model_reset();
        repeat (2) cycle();
        chk("rst_out4", out4, 0);
        chk("rst_busy4", busy4, 0);
        rst = 1'b0;

        // Clean rise
        in4 = 1'b1;
        for (int e = 0; e < 7; e++) begin
            cycle();
            chk("rise_busy", busy4, (e >= 2 && e <= 4));
            chk("rise_out", out4, (e >= 5));
        end

        // Clean fall
        in4 = 1'b0;
        for (int e = 0; e < 7; e++) begin
            cycle();
            chk("fall_busy", busy4, (e >= 2 && e <= 4));
            chk("fall_out", out4, (e < 5));
        end

        // Short glitch
        bcnt = 0;
        in4  = 1'b1;
        for (int e = 0; e < 9; e++) begin
            if (e == 3) in4 = 1'b0;
            cycle();
            if (busy4) bcnt++;
            chk("glitch_out", out4, 0);
        end
        chk("glitch_busycnt", bcnt, 3);

        // Bounce then settle
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            in4 = pat[i];
            cycle();
            chk("bounce_out", out4, 0);
        end
        n = 1;
        while (!out4 && n < 20) begin
            cycle();
            n++;
        end
        chk("bounce_lat", n, 6);

        // Reset mid-count
        in4 = 1'b0;
        repeat (8) cycle();
        in4 = 1'b1;
        repeat (4) cycle();
        chk("midrst_busy_pre", busy4, 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_out", out4, 0);
        chk("midrst_busy", busy4, 0);
        cycle();
        rst = 1'b0;
        n = 0;
        while (!out4 && n < 20) begin
            cycle();
            n++;
        end
        chk("midrst_lat", n, 6);

        // Randomized held levels of varying length
        for (int k = 0; k < 150; k++) begin
            in4 = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 8)) cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
